// File: rtl/gppcu_issue_pipe.sv
// rtl/gppcu_issue_pipe.sv - In-order issue front-end: instruction FIFO, register scoreboard, broadcast pipeline.
// Optional macro GPPCU_WB_BYPASS_EN lets a writeback-stage clear satisfy a hazard in the same cycle.
module gppcu_issue_pipe #(
  parameter int DBW        = 32,
  parameter int NUMREG     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int PIPE_LAT   = 3,
  parameter int REGD_LSB   = 22,
  parameter int REGA_LSB   = 17,
  parameter int REGB_LSB   = 12
) (
  input  logic                            iACLK,
  input  logic                            inRST,
  input  logic [DBW-1:0]                  iINSTR,
  input  logic [2:0]                      iINSTR_FLAGS,
  input  logic                            iINSTR_VALID,
  output logic                            oINSTR_READY,
  input  logic                            iBUSY,
  input  logic                            iFLUSH,
  output logic                            oISSUE,
  output logic [PIPE_LAT-1:0]             oPIPE_VALID,
  output logic [PIPE_LAT*DBW-1:0]         oPIPE_INSTR,
  output logic [PIPE_LAT-1:0]             oPIPE_WR,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] oLEVEL,
  output logic                            oIDLE
);
  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int RIW = (NUMREG > 1) ? $clog2(NUMREG) : 1;
  localparam int EW  = DBW + 3;

  logic [EW-1:0]                mem_q [FIFO_DEPTH];
  logic [EW-1:0]                mem_d [FIFO_DEPTH];
  logic [PW-1:0]                rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]                level_q, level_d;
  logic [NUMREG-1:0]            pend_q, pend_d, pend_eff, clr_mask, set_mask;
  logic [PIPE_LAT-1:0]          pipe_valid_q, pipe_valid_d, pipe_wr_q, pipe_wr_d;
  logic [PIPE_LAT-1:0][DBW-1:0] pipe_instr_q, pipe_instr_d;

  logic [DBW-1:0] head_instr;
  logic [2:0]     head_flags;
  logic [RIW-1:0] reg_d, reg_a, reg_b, wb_reg;
  logic           dest_nz, wr_eff, hazard, issue, push;

  assign head_instr = mem_q[rd_ptr_q][DBW-1:0];
  assign head_flags = mem_q[rd_ptr_q][EW-1:DBW];
  assign reg_d      = head_instr[REGD_LSB +: RIW];
  assign reg_a      = head_instr[REGA_LSB +: RIW];
  assign reg_b      = head_instr[REGB_LSB +: RIW];
  assign dest_nz    = head_instr[REGD_LSB +: 5] != 5'd0;
  assign wr_eff     = head_flags[2] & dest_nz;
  assign wb_reg     = pipe_instr_q[PIPE_LAT-1][REGD_LSB +: RIW];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    clr_mask = '0;
    if (pipe_valid_q[PIPE_LAT-1] && pipe_wr_q[PIPE_LAT-1]) clr_mask[wb_reg] = 1'b1;
`ifdef GPPCU_WB_BYPASS_EN
    pend_eff = pend_q & ~clr_mask;
`else
    pend_eff = pend_q;
`endif
    hazard = (head_flags[0] & pend_eff[reg_a]) |
             (head_flags[1] & pend_eff[reg_b]) |
             (head_flags[2] & pend_eff[reg_d]);
    issue = (level_q != '0) & ~iBUSY & ~iFLUSH & ~hazard;
    set_mask = '0;
    if (issue && wr_eff) set_mask[reg_d] = 1'b1;
    // Set is OR'd after the clear so a bypassed WAW keeps the register pending.
    pend_d    = (pend_q & ~clr_mask) | set_mask;
    pend_d[0] = 1'b0;
  end

  always_comb begin
    pipe_valid_d    = '0;
    pipe_wr_d       = '0;
    pipe_instr_d    = '0;
    pipe_valid_d[0] = issue;
    pipe_wr_d[0]    = issue & wr_eff;
    pipe_instr_d[0] = issue ? head_instr : '0;
    for (int k = 1; k < PIPE_LAT; k++) begin
      pipe_valid_d[k] = pipe_valid_q[k-1];
      pipe_wr_d[k]    = pipe_wr_q[k-1];
      pipe_instr_d[k] = pipe_instr_q[k-1];
    end
  end

  always_comb begin
    push     = iINSTR_VALID & oINSTR_READY & ~iFLUSH;
    mem_d    = mem_q;
    rd_ptr_d = issue ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    level_d  = level_q + LW'(push) - LW'(issue);
    if (push) mem_d[wr_ptr_q] = {iINSTR_FLAGS, iINSTR};
    if (iFLUSH) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      pend_q       <= '0;
      pipe_valid_q <= '0;
      pipe_wr_q    <= '0;
      pipe_instr_q <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      level_q      <= level_d;
      pend_q       <= pend_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_wr_q    <= pipe_wr_d;
      pipe_instr_q <= pipe_instr_d;
    end
  end

  assign oINSTR_READY = level_q < LW'(FIFO_DEPTH);
  assign oISSUE       = issue;
  assign oPIPE_VALID  = pipe_valid_q;
  assign oPIPE_WR     = pipe_wr_q;
  assign oPIPE_INSTR  = pipe_instr_q;
  assign oLEVEL       = level_q;
  assign oIDLE        = (level_q == '0) & ~|pipe_valid_q & ~|pend_q;
endmodule

// File: tb/tb_gppcu_issue_pipe.sv
// tb/tb_gppcu_issue_pipe.sv - Directed vector bench for gppcu_issue_pipe at default parameters.
module tb_gppcu_issue_pipe;
  localparam int DBW = 32;
  localparam int PL  = 3;

  logic          iACLK = 1'b0;
  logic          inRST;
  logic [31:0]   iINSTR;
  logic [2:0]    iINSTR_FLAGS;
  logic          iINSTR_VALID, iBUSY, iFLUSH;
  logic          oINSTR_READY, oISSUE, oIDLE;
  logic [2:0]    oPIPE_VALID, oPIPE_WR, oLEVEL;
  logic [95:0]   oPIPE_INSTR;

  int errors = 0;
  int checks = 0;

  always #5 iACLK = ~iACLK;

  gppcu_issue_pipe dut (
    .iACLK(iACLK), .inRST(inRST), .iINSTR(iINSTR), .iINSTR_FLAGS(iINSTR_FLAGS),
    .iINSTR_VALID(iINSTR_VALID), .oINSTR_READY(oINSTR_READY), .iBUSY(iBUSY),
    .iFLUSH(iFLUSH), .oISSUE(oISSUE), .oPIPE_VALID(oPIPE_VALID),
    .oPIPE_INSTR(oPIPE_INSTR), .oPIPE_WR(oPIPE_WR), .oLEVEL(oLEVEL), .oIDLE(oIDLE)
  );

  typedef struct packed {
    logic        vld;
    logic [31:0] ins;
    logic [2:0]  flg;
    logic        busy;
    logic        flush;
    logic        rdy;
    logic        iss;
    logic [2:0]  pv;
    logic [2:0]  pw;
    logic [2:0]  lvl;
    logic        idle;
  } vec_t;

  vec_t tbl [27];

  function automatic logic [31:0] mk(input int d, input int a, input int b, input int tag);
    logic [31:0] r;
    r = '0;
    r[22 +: 5] = d[4:0];
    r[17 +: 5] = a[4:0];
    r[12 +: 5] = b[4:0];
    r[11:0]    = tag[11:0];
    return r;
  endfunction

  function automatic vec_t mkv(input logic vld, input logic [31:0] ins, input logic [2:0] flg,
                               input logic busy, input logic rdy, input logic iss,
                               input logic [2:0] pv, input logic [2:0] pw,
                               input logic [2:0] lvl, input logic idle);
    vec_t v;
    v.vld = vld; v.ins = ins; v.flg = flg; v.busy = busy; v.flush = 1'b0;
    v.rdy = rdy; v.iss = iss; v.pv = pv; v.pw = pw; v.lvl = lvl; v.idle = idle;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [31:0] ins, input logic [2:0] flg,
                       input logic busy, input logic flush);
    iINSTR_VALID = vld;
    iINSTR       = ins;
    iINSTR_FLAGS = flg;
    iBUSY        = busy;
    iFLUSH       = flush;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    drive(1'b0, '0, 3'b000, 1'b0, 1'b0);
    while (!oIDLE && n < 20) begin
      @(negedge iACLK);
      #1;
      n++;
    end
    chk(nm, oIDLE, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, bubbles, acc;
    logic found;

    // Independent R1..R4 stream, R0 write/read, and a two-cycle busy pulse.
    tbl[0]  = mkv(1, mk(1,0,0,1),  3'b100, 0, 1, 0, 3'b000, 3'b000, 0, 1);
    tbl[1]  = mkv(1, mk(2,0,0,2),  3'b100, 0, 1, 1, 3'b000, 3'b000, 1, 0);
    tbl[2]  = mkv(1, mk(3,0,0,3),  3'b100, 0, 1, 1, 3'b001, 3'b001, 1, 0);
    tbl[3]  = mkv(1, mk(4,0,0,4),  3'b100, 0, 1, 1, 3'b011, 3'b011, 1, 0);
    tbl[4]  = mkv(0, '0, 3'b000, 0, 1, 1, 3'b111, 3'b111, 1, 0);
    tbl[5]  = mkv(0, '0, 3'b000, 0, 1, 0, 3'b111, 3'b111, 0, 0);
    tbl[6]  = mkv(0, '0, 3'b000, 0, 1, 0, 3'b110, 3'b110, 0, 0);
    tbl[7]  = mkv(0, '0, 3'b000, 0, 1, 0, 3'b100, 3'b100, 0, 0);
    tbl[8]  = mkv(0, '0, 3'b000, 0, 1, 0, 3'b000, 3'b000, 0, 1);
    tbl[9]  = mkv(1, mk(0,0,0,9),  3'b100, 0, 1, 0, 3'b000, 3'b000, 0, 1);
    tbl[10] = mkv(1, mk(0,0,0,10), 3'b001, 0, 1, 1, 3'b000, 3'b000, 1, 0);
    tbl[11] = mkv(0, '0, 3'b000, 0, 1, 1, 3'b001, 3'b000, 1, 0);
    tbl[12] = mkv(0, '0, 3'b000, 0, 1, 0, 3'b011, 3'b000, 0, 0);
    tbl[13] = mkv(0, '0, 3'b000, 0, 1, 0, 3'b110, 3'b000, 0, 0);
    tbl[14] = mkv(0, '0, 3'b000, 0, 1, 0, 3'b100, 3'b000, 0, 0);
    tbl[15] = mkv(0, '0, 3'b000, 0, 1, 0, 3'b000, 3'b000, 0, 1);
    tbl[16] = mkv(1, mk(8,0,0,16),  3'b100, 0, 1, 0, 3'b000, 3'b000, 0, 1);
    tbl[17] = mkv(1, mk(9,0,0,17),  3'b100, 0, 1, 1, 3'b000, 3'b000, 1, 0);
    tbl[18] = mkv(1, mk(10,0,0,18), 3'b100, 1, 1, 0, 3'b001, 3'b001, 1, 0);
    tbl[19] = mkv(1, mk(11,0,0,19), 3'b100, 1, 1, 0, 3'b010, 3'b010, 2, 0);
    tbl[20] = mkv(0, '0, 3'b000, 0, 1, 1, 3'b100, 3'b100, 3, 0);
    tbl[21] = mkv(0, '0, 3'b000, 0, 1, 1, 3'b001, 3'b001, 2, 0);
    tbl[22] = mkv(0, '0, 3'b000, 0, 1, 1, 3'b011, 3'b011, 1, 0);
    tbl[23] = mkv(0, '0, 3'b000, 0, 1, 0, 3'b111, 3'b111, 0, 0);
    tbl[24] = mkv(0, '0, 3'b000, 0, 1, 0, 3'b110, 3'b110, 0, 0);
    tbl[25] = mkv(0, '0, 3'b000, 0, 1, 0, 3'b100, 3'b100, 0, 0);
    tbl[26] = mkv(0, '0, 3'b000, 0, 1, 0, 3'b000, 3'b000, 0, 1);

    inRST = 1'b0;
    drive(1'b0, '0, 3'b000, 1'b0, 1'b0);
    repeat (2) @(negedge iACLK);
    #1;
    chk("reset ready", oINSTR_READY, 1'b1);
    chk("reset issue", oISSUE, 1'b0);
    chk("reset pipe_valid", oPIPE_VALID, 3'b000);
    chk("reset pipe_wr", oPIPE_WR, 3'b000);
    chk("reset pipe_instr", oPIPE_INSTR, 96'h0);
    chk("reset level", oLEVEL, 3'd0);
    chk("reset idle", oIDLE, 1'b1);
    inRST = 1'b1;

    for (int i = 0; i < 27; i++) begin
      @(negedge iACLK);
      drive(tbl[i].vld, tbl[i].ins, tbl[i].flg, tbl[i].busy, tbl[i].flush);
      #1;
      chk($sformatf("row%0d ready", i), oINSTR_READY, tbl[i].rdy);
      chk($sformatf("row%0d issue", i), oISSUE, tbl[i].iss);
      chk($sformatf("row%0d pipe_valid", i), oPIPE_VALID, tbl[i].pv);
      chk($sformatf("row%0d pipe_wr", i), oPIPE_WR, tbl[i].pw);
      chk($sformatf("row%0d level", i), oLEVEL, tbl[i].lvl);
      chk($sformatf("row%0d idle", i), oIDLE, tbl[i].idle);
    end
    chk("row26 stage2 instr", oPIPE_INSTR[2*DBW +: DBW], 32'h0);

    // RAW on R5: writer then reader.
    @(negedge iACLK);
    drive(1'b1, mk(5,0,0,40), 3'b100, 1'b0, 1'b0);
    #1;
    chk("raw empty no issue", oISSUE, 1'b0);
    @(negedge iACLK);
    drive(1'b1, mk(6,5,0,41), 3'b101, 1'b0, 1'b0);
    #1;
    chk("raw writer issue", oISSUE, 1'b1);
    gap = 0;
    bubbles = 0;
    found = 1'b0;
    for (int c = 1; c <= 10 && !found; c++) begin
      @(negedge iACLK);
      drive(1'b0, '0, 3'b000, 1'b0, 1'b0);
      #1;
      if (c >= 2 && !oPIPE_VALID[0]) bubbles++;
      if (oISSUE) begin
        found = 1'b1;
        gap = c;
      end
    end
    chk("raw reader issued", found, 1'b1);
`ifdef GPPCU_WB_BYPASS_EN
    chk("raw issue gap", gap, PL);
    chk("raw stage0 bubbles", bubbles, PL - 1);
`else
    chk("raw issue gap", gap, PL + 1);
    chk("raw stage0 bubbles", bubbles, PL);
`endif
    wait_idle("raw drain idle");

    // Full FIFO under busy; the fifth word waits for a real issue.
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge iACLK);
      drive(1'b1, mk(12 + acc, 0, 0, 50 + acc), 3'b100, 1'b1, 1'b0);
      #1;
      if (oINSTR_READY) acc++;
    end
    chk("full accepted count", acc, 4);
    chk("full level", oLEVEL, 3'd4);
    chk("full ready", oINSTR_READY, 1'b0);
    chk("full busy no issue", oISSUE, 1'b0);
    @(negedge iACLK);
    drive(1'b1, mk(16,0,0,60), 3'b100, 1'b0, 1'b0);
    #1;
    chk("full pop issue", oISSUE, 1'b1);
    chk("full pop ready", oINSTR_READY, 1'b0);
    @(negedge iACLK);
    #1;
    chk("full after pop level", oLEVEL, 3'd3);
    chk("full after pop ready", oINSTR_READY, 1'b1);
    wait_idle("full drain idle");

    // Flush with 3 buffered and 2 in flight.
    for (int i = 0; i < 4; i++) begin
      @(negedge iACLK);
      drive(1'b1, mk(20 + i, 0, 0, 70 + i), 3'b100, 1'b1, 1'b0);
    end
    @(negedge iACLK);
    drive(1'b0, '0, 3'b000, 1'b0, 1'b0);
    #1;
    chk("flush pre issue1", oISSUE, 1'b1);
    @(negedge iACLK);
    drive(1'b1, mk(24,0,0,74), 3'b100, 1'b0, 1'b0);
    #1;
    chk("flush pre issue2", oISSUE, 1'b1);
    @(negedge iACLK);
    drive(1'b1, mk(25,0,0,75), 3'b100, 1'b0, 1'b1);
    #1;
    chk("flush cycle level", oLEVEL, 3'd3);
    chk("flush cycle issue", oISSUE, 1'b0);
    chk("flush cycle pipe_valid", oPIPE_VALID, 3'b011);
    @(negedge iACLK);
    drive(1'b0, '0, 3'b000, 1'b0, 1'b0);
    #1;
    chk("flush next level", oLEVEL, 3'd0);
    chk("flush next ready", oINSTR_READY, 1'b1);
    chk("flush next pipe_valid", oPIPE_VALID, 3'b110);
    chk("flush next idle", oIDLE, 1'b0);
    @(negedge iACLK);
    #1;
    chk("flush wb pipe_valid", oPIPE_VALID, 3'b100);
    chk("flush wb instr", oPIPE_INSTR[2*DBW +: DBW], mk(21,0,0,71));
    chk("flush wb idle", oIDLE, 1'b0);
    chk("flush wb level", oLEVEL, 3'd0);
    @(negedge iACLK);
    #1;
    chk("flush done idle", oIDLE, 1'b1);
    chk("flush done pipe_valid", oPIPE_VALID, 3'b000);

    // Asynchronous reset mid-operation.
    @(negedge iACLK);
    drive(1'b1, mk(3,0,0,80), 3'b100, 1'b0, 1'b0);
    @(negedge iACLK);
    drive(1'b1, mk(4,0,0,81), 3'b100, 1'b0, 1'b0);
    @(negedge iACLK);
    drive(1'b0, '0, 3'b000, 1'b0, 1'b0);
    #1;
    chk("prereset pipe_valid", oPIPE_VALID, 3'b001);
    #1;
    inRST = 1'b0;
    #1;
    chk("async reset level", oLEVEL, 3'd0);
    chk("async reset pipe_valid", oPIPE_VALID, 3'b000);
    chk("async reset idle", oIDLE, 1'b1);
    chk("async reset ready", oINSTR_READY, 1'b1);
    @(negedge iACLK);
    inRST = 1'b1;
    @(negedge iACLK);
    #1;
    chk("post reset issue", oISSUE, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
